// File: rtl/axi_write_router_1x4.sv
// Routes one master's W burst to the slave chosen at AW time, then returns that
// slave's B response. Only one burst is in flight at a time.
module axi_write_router_1x4 #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [1:0]            aw_sel,
  input  logic [LEN_WIDTH-1:0]  aw_len,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wlast,
  output logic [3:0]            m_wvalid,
  input  logic [3:0]            m_wready,
  input  logic [7:0]            m_bresp,
  input  logic [3:0]            m_bvalid,
  output logic [3:0]            m_bready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic                  busy,
  output logic                  wlast_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q;
  logic [1:0]           sel_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt_q;
  logic                 wlast_err_q;

  logic [3:0] sel_onehot_s;
  logic       last_beat_s;
  logic       w_hs_s;
  logic       b_hs_s;

  // Channel steering is a pure decode of the current state so data and
  // handshakes pass through with no added latency.
  always_comb begin
    sel_onehot_s = 4'b0001 << sel_q;
    last_beat_s  = (beat_cnt_q == len_q);
    aw_ready     = 1'b0;
    busy         = 1'b1;
    s_wready     = 1'b0;
    m_wvalid     = 4'b0000;
    m_wlast      = 1'b0;
    m_bready     = 4'b0000;
    s_bvalid     = 1'b0;
    s_bresp      = 2'b00;
    case (state_q)
      IDLE: begin
        aw_ready = 1'b1;
        busy     = 1'b0;
      end
      DATA: begin
        m_wvalid = sel_onehot_s & {4{s_wvalid}};
        s_wready = m_wready[sel_q];
        m_wlast  = last_beat_s;
      end
      RESP: begin
        s_bvalid = m_bvalid[sel_q];
        s_bresp  = m_bresp[{sel_q, 1'b0} +: 2];
        m_bready = sel_onehot_s & {4{s_bready}};
      end
      default: begin
        busy = 1'b1;
      end
    endcase
    w_hs_s = s_wvalid & s_wready;
    b_hs_s = s_bvalid & s_bready;
  end

  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign wlast_err = wlast_err_q;

  // Burst sequencing follows the beat count only; the master's WLAST is
  // merely cross-checked and a disagreement raises a one-cycle error pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      len_q       <= {LEN_WIDTH{1'b0}};
      beat_cnt_q  <= {LEN_WIDTH{1'b0}};
      wlast_err_q <= 1'b0;
    end else begin
      wlast_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aw_valid) begin
            sel_q      <= aw_sel;
            len_q      <= aw_len;
            beat_cnt_q <= {LEN_WIDTH{1'b0}};
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_hs_s) begin
            wlast_err_q <= s_wlast ^ last_beat_s;
            if (last_beat_s) begin
              state_q <= RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        RESP: begin
          if (b_hs_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_router_1x4.sv
// Self-checking bench for axi_write_router_1x4: table-driven single-beat bursts,
// hand-written corner sequences and randomized traffic against a transaction model.
module tb_axi_write_router_1x4;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          aw_valid;
  logic          aw_ready;
  logic [1:0]    aw_sel;
  logic [LW-1:0] aw_len;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast;
  logic          s_wvalid;
  logic          s_wready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast;
  logic [3:0]    m_wvalid;
  logic [3:0]    m_wready;
  logic [7:0]    m_bresp;
  logic [3:0]    m_bvalid;
  logic [3:0]    m_bready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic          busy;
  logic          wlast_err;

  axi_write_router_1x4 #(.DATA_WIDTH(DW), .STRB_WIDTH(SW), .LEN_WIDTH(LW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_sel(aw_sel), .aw_len(aw_len),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .busy(busy), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: is a burst open, is it waiting for B,
  // which slave, how many beats in total and how many moved so far.
  bit mdl_active;
  bit mdl_resp;
  int mdl_sel;
  int mdl_beats;
  int mdl_done;
  bit mdl_err;

  logic [DW-1:0] got_q[$];
  int dut_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_active = 1'b0;
    mdl_resp   = 1'b0;
    mdl_sel    = 0;
    mdl_beats  = 0;
    mdl_done   = 0;
    mdl_err    = 1'b0;
  endtask

  task automatic model_update();
    if (ARESET) begin
      model_reset();
    end else begin
      mdl_err = 1'b0;
      if (!mdl_active) begin
        if (aw_valid) begin
          mdl_active = 1'b1;
          mdl_resp   = 1'b0;
          mdl_sel    = int'(aw_sel);
          mdl_beats  = int'(aw_len) + 1;
          mdl_done   = 0;
        end
      end else if (!mdl_resp) begin
        if (s_wvalid && m_wready[mdl_sel]) begin
          mdl_err = (s_wlast != (mdl_done == mdl_beats - 1));
          mdl_done++;
          if (mdl_done == mdl_beats) mdl_resp = 1'b1;
        end
      end else if (m_bvalid[mdl_sel] && s_bready) begin
        mdl_active = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    bit         in_data;
    bit         in_resp;
    logic [3:0] onehot;
    in_data = mdl_active && !mdl_resp;
    in_resp = mdl_active && mdl_resp;
    onehot  = 4'(1 << mdl_sel);
    chk("aw_ready", aw_ready, !mdl_active);
    chk("busy", busy, mdl_active);
    chk("m_wvalid", m_wvalid, (in_data && s_wvalid) ? onehot : 4'b0000);
    chk("s_wready", s_wready, in_data ? m_wready[mdl_sel] : 1'b0);
    chk("m_wlast", m_wlast, in_data && (mdl_done == mdl_beats - 1));
    chk("m_wdata", m_wdata, s_wdata);
    chk("m_wstrb", m_wstrb, s_wstrb);
    chk("s_bvalid", s_bvalid, in_resp ? m_bvalid[mdl_sel] : 1'b0);
    chk("s_bresp", s_bresp, in_resp ? m_bresp[2*mdl_sel +: 2] : 2'b00);
    chk("m_bready", m_bready, (in_resp && s_bready) ? onehot : 4'b0000);
    chk("wlast_err", wlast_err, mdl_err);
  endtask

  // Inputs are applied just after a falling edge; outputs are checked 1ns later.
  task automatic cycle();
    #1;
    check_all();
    if (|(m_wvalid & m_wready)) begin
      got_q.push_back(m_wdata);
      dut_hs++;
    end
    @(posedge ACLK);
    model_update();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    aw_valid = 1'b0;
    aw_sel   = 2'd0;
    aw_len   = 8'd0;
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    s_wdata  = $urandom;
    s_wstrb  = 4'($urandom);
    m_wready = 4'b0000;
    m_bvalid = 4'b0000;
    m_bresp  = 8'h00;
    s_bready = 1'b0;
  endtask

  task automatic do_aw(input logic [1:0] sel, input logic [LW-1:0] len);
    aw_valid = 1'b1;
    aw_sel   = sel;
    aw_len   = len;
    s_wvalid = 1'b1;
    m_wready = 4'b1111;
    cycle();
    aw_valid = 1'b0;
    s_wvalid = 1'b0;
  endtask

  task automatic respond(input logic [3:0] bv);
    s_wvalid = 1'b0;
    m_bvalid = bv;
    m_bresp  = 8'h00;
    s_bready = 1'b1;
    cycle();
    idle_inputs();
    cycle();
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [3:0]  exp_wvalid;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t tbl[4];
  logic [DW-1:0] d4[4];

  initial begin
    tbl[0] = '{2'd2, 32'hDEADBEEF, 4'hF, 2'b00, 4'b0100, 2'b00};
    tbl[1] = '{2'd0, 32'h12345678, 4'h3, 2'b01, 4'b0001, 2'b01};
    tbl[2] = '{2'd1, 32'hA5A5F00F, 4'h8, 2'b10, 4'b0010, 2'b10};
    tbl[3] = '{2'd3, 32'h0BADCAFE, 4'h5, 2'b11, 4'b1000, 2'b11};

    // Reset with live traffic on the inputs
    idle_inputs();
    ARESET   = 1'b1;
    s_wvalid = 1'b1;
    m_bvalid = 4'hF;
    s_bready = 1'b1;
    model_reset();
    #2;
    chk("rst_aw_ready", aw_ready, 1'b1);
    chk("rst_m_wvalid", m_wvalid, 4'b0000);
    chk("rst_m_bready", m_bready, 4'b0000);
    chk("rst_s_bvalid", s_bvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge ACLK);
    cycle();
    ARESET = 1'b0;
    idle_inputs();
    cycle();

    // Single-beat bursts to every slave
    for (int i = 0; i < 4; i++) begin
      do_aw(tbl[i].sel, 8'd0);
      s_wdata  = tbl[i].data;
      s_wstrb  = tbl[i].strb;
      s_wlast  = 1'b1;
      s_wvalid = 1'b1;
      m_wready = ~tbl[i].exp_wvalid;
      #1;
      chk("tbl_stall_s_wready", s_wready, 1'b0);
      cycle();
      m_wready = 4'b1111;
      #1;
      chk("tbl_m_wvalid", m_wvalid, tbl[i].exp_wvalid);
      chk("tbl_m_wlast", m_wlast, 1'b1);
      chk("tbl_m_wdata", m_wdata, tbl[i].data);
      cycle();
      s_wvalid = 1'b0;
      m_bresp  = {4{~tbl[i].bresp}};
      m_bresp[2*tbl[i].sel +: 2] = tbl[i].bresp;
      m_bvalid = tbl[i].exp_wvalid;
      s_bready = 1'b1;
      #1;
      chk("tbl_s_bvalid", s_bvalid, 1'b1);
      chk("tbl_s_bresp", s_bresp, tbl[i].exp_bresp);
      cycle();
      idle_inputs();
      #1;
      chk("tbl_back_idle", aw_ready, 1'b1);
      cycle();
    end

    // 4-beat burst with toggling slave ready
    do_aw(2'd1, 8'd3);
    got_q.delete();
    dut_hs = 0;
    for (int i = 0; i < 4; i++) d4[i] = $urandom;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 8; c++) begin
        m_wready    = 4'($urandom);
        m_wready[1] = (c % 2 == 0);
        s_wvalid    = 1'b1;
        s_wdata     = (k < 4) ? d4[k] : 32'h0;
        s_wlast     = (k == 3);
        cycle();
        if (c % 2 == 0) k++;
      end
    end
    chk("bp_handshakes", dut_hs, 4);
    for (int i = 0; i < 4; i++) chk("bp_data_order", (i < got_q.size()) ? got_q[i] : 32'hx, d4[i]);
    respond(4'b0010);

    // Early WLAST: error pulse, burst still runs to its count
    do_aw(2'd0, 8'd1);
    s_wvalid = 1'b1;
    m_wready = 4'b1111;
    s_wlast  = 1'b1;
    cycle();
    #1;
    chk("mis_err_pulse", wlast_err, 1'b1);
    chk("mis_still_data", s_wready, 1'b1);
    cycle();
    #1;
    chk("mis_err_cleared", wlast_err, 1'b0);
    chk("mis_in_resp", s_wready, 1'b0);
    respond(4'b0001);

    // Maximum-length burst
    do_aw(2'd2, 8'd255);
    dut_hs   = 0;
    s_wvalid = 1'b1;
    m_wready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      s_wdata = i;
      s_wlast = (i == 255);
      cycle();
    end
    #1;
    chk("max_handshakes", dut_hs, 256);
    chk("max_left_data", s_wready, 1'b0);
    chk("max_busy", busy, 1'b1);
    respond(4'b0100);

    // Response isolation: another slave's B is never seen or acknowledged
    do_aw(2'd3, 8'd0);
    s_wvalid = 1'b1;
    s_wlast  = 1'b1;
    m_wready = 4'b1000;
    cycle();
    s_wvalid = 1'b0;
    m_bvalid = 4'b0001;
    m_bresp  = 8'b00_00_00_10;
    s_bready = 1'b1;
    #1;
    chk("iso_s_bvalid", s_bvalid, 1'b0);
    chk("iso_m_bready", m_bready, 4'b1000);
    cycle();
    m_bvalid = 4'b1001;
    #1;
    chk("iso_sel_bvalid", s_bvalid, 1'b1);
    chk("iso_sel_bresp", s_bresp, 2'b00);
    chk("iso_sel_bready", m_bready, 4'b1000);
    cycle();
    idle_inputs();
    cycle();

    // Reset in the middle of a burst, then a fresh burst
    do_aw(2'd1, 8'd3);
    s_wvalid = 1'b1;
    m_wready = 4'b1111;
    cycle();
    cycle();
    ARESET = 1'b1;
    model_reset();
    #1;
    chk("mrst_m_wvalid", m_wvalid, 4'b0000);
    chk("mrst_busy", busy, 1'b0);
    cycle();
    ARESET = 1'b0;
    idle_inputs();
    cycle();
    do_aw(2'd0, 8'd0);
    s_wvalid = 1'b1;
    s_wlast  = 1'b1;
    m_wready = 4'b0001;
    #1;
    chk("mrst_new_wvalid", m_wvalid, 4'b0001);
    cycle();
    respond(4'b0001);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ARESET   = ($urandom_range(0, 299) == 0);
      if (ARESET) model_reset();
      aw_valid = ($urandom_range(0, 1) == 1);
      aw_sel   = 2'($urandom);
      aw_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
      s_wvalid = ($urandom_range(0, 9) < 7);
      s_wdata  = $urandom;
      s_wstrb  = 4'($urandom);
      if (mdl_active && !mdl_resp && $urandom_range(0, 7) != 0)
        s_wlast = (mdl_done == mdl_beats - 1);
      else
        s_wlast = 1'($urandom);
      m_wready = 4'($urandom);
      m_bvalid = 4'($urandom);
      m_bresp  = 8'($urandom);
      s_bready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_write_router_1x4.md
Name: axi_write_router_1x4

Overview:
- Write-direction counterpart of the 4-slave read-return path.
- Routes one master's W channel to one of 4 slave ports, selected by the slave index captured at the AW handshake.
- Then returns the selected slave's B response to the master.
- Handles one burst at a time; sits between the write address arbiter/decoder and the slave-side W/B channels of the interconnect.

Parameters:
DATA_WIDTH, 32, W data width in bits
STRB_WIDTH, DATA_WIDTH/8, write strobe width
LEN_WIDTH, 8, burst length field width (beats = len+1)

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESET  in  1  asynchronous, active-high reset
aw_valid  in  1  routing request (slave chosen, burst accepted upstream)
aw_ready  out  1  router can accept a new burst
aw_sel  in  2  target slave index 0..3
aw_len  in  LEN_WIDTH  burst length minus one
s_wdata  in  DATA_WIDTH  master write data
s_wstrb  in  STRB_WIDTH  master write strobe
s_wlast  in  1  master last-beat flag
s_wvalid  in  1  master W valid
s_wready  out  1  master W ready
m_wdata  out  DATA_WIDTH  broadcast to all 4 slaves
m_wstrb  out  STRB_WIDTH  broadcast to all 4 slaves
m_wlast  out  1  router-generated last flag, broadcast
m_wvalid  out  4  one-hot per-slave W valid
m_wready  in  4  per-slave W ready
m_bresp  in  8  slave k response at bits [2k+1:2k]
m_bvalid  in  4  per-slave B valid
m_bready  out  4  per-slave B ready
s_bresp  out  2  response to master
s_bvalid  out  1  B valid to master
s_bready  in  1  master B ready
busy  out  1  state != IDLE
wlast_err  out  1  one-cycle pulse on WLAST/length mismatch

Behaviour:

Reset:
- ARESET high forces state=IDLE, sel_q=0, len_q=0, beat_cnt=0, wlast_err=0 immediately (async).
- Outputs while in reset: aw_ready=1 (IDLE decode), busy=0, s_wready=0, m_wvalid=0, m_bready=0, s_bvalid=0, s_bresp=0, m_wlast=0.

State machine: IDLE, DATA, RESP.

IDLE:
- aw_ready=1.
- aw_valid&aw_ready registers sel_q<=aw_sel, len_q<=aw_len, beat_cnt<=0 -> DATA.
- s_wready=0; W beats arriving early stall.

DATA:
- Combinational pass-through, zero added latency.
- m_wvalid[sel_q]=s_wvalid; other bits 0.
- s_wready=m_wready[sel_q].
- m_wdata/m_wstrb = s_wdata/s_wstrb always.
- m_wlast = (beat_cnt==len_q) in DATA, else 0.
- On a beat handshake (s_wvalid&s_wready):
  - If beat_cnt==len_q: -> RESP.
  - Else: beat_cnt+1.
- beat_cnt never wraps: max len 255 gives 256 beats, exits at count 255.
- Mismatch (handshake with s_wlast != (beat_cnt==len_q)): wlast_err=1 the next cycle only.
- The burst still ends on the count; s_wlast is never used for sequencing.

RESP:
- s_bvalid=m_bvalid[sel_q], s_bresp=m_bresp[sel_q], m_bready[sel_q]=s_bready; other m_bready=0.
- m_bvalid of non-selected slaves is ignored and never acknowledged.
- B handshake -> IDLE; the next AW is accepted no earlier than the following cycle.

Other rules:
- aw_valid outside IDLE: ignored, aw_ready=0.
- m_bvalid[sel_q] asserted during DATA: ignored until RESP.
- Reset mid-burst or mid-response abandons the transaction; the outputs listed above drop in the same cycle.

Test Plan:
- Reset: ARESET=1 with s_wvalid=1, m_bvalid=4'hF -> aw_ready=1, m_wvalid=0, m_bready=0, s_bvalid=0, busy=0.
- Single beat: aw_sel=2, aw_len=0, then beat 0xDEADBEEF, wstrb=0xF, wlast=1 -> m_wvalid=4'b0100, m_wlast=1, s_wready follows m_wready[2]. Then m_bvalid[2]=1, bresp=2'b00 -> s_bvalid=1, s_bresp=0, IDLE next cycle.
- 4-beat backpressure: aw_sel=1, aw_len=3, m_wready[1] toggling 1,0,1,0 -> exactly 4 handshakes, data order preserved, m_wlast high only on beat 3, no wlast_err.
- WLAST mismatch: aw_len=1 with s_wlast=1 on beat 0 -> wlast_err pulses one cycle, burst still takes 2 beats. Also 256-beat burst (aw_len=255) -> exits DATA after beat 255.
- Response isolation: sel=3 in RESP, m_bvalid=4'b0001 with bresp0=SLVERR -> s_bvalid=0; then m_bvalid[3]=1, bresp3=OKAY -> s_bresp=0, m_bready=4'b1000 while s_bready=1.
- Mid-burst reset: ARESET asserted after beat 1 of a 4-beat burst -> m_wvalid=0, busy=0 immediately. A new burst with aw_sel=0 after release routes correctly.
